nphy_toggle_input_capture: RTL and testbench

NPHY_TOGGLE_INPUT_CAPTURE -- requirements
Module: nphy_toggle_input_capture

---
 rtl/nphy_toggle_pkg.sv | 12 +
 rtl/nphy_sync_fifo.sv | 66 ++++++
 rtl/nphy_toggle_input_capture.sv | 141 ++++++++++++++
 tb/tb_nphy_toggle_input_capture.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nphy_toggle_pkg.sv
// Shared constants and sample/word types for the NAND PHY toggle-mode read capture path.
package nphy_toggle_pkg;

    localparam int SAMPLES_PER_CLK = 8;
    localparam int BYTES_PER_WORD  = 4;
    localparam int RD_FIFO_DEPTH   = 8;

    typedef logic [SAMPLES_PER_CLK-1:0]      dqs_vec_t;
    typedef logic [SAMPLES_PER_CLK-1:0][7:0] dq_vec_t;
    typedef logic [BYTES_PER_WORD-1:0][7:0]  word_t;

endpackage

// File: rtl/nphy_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO without a pop is dropped.
module nphy_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_FULL);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (push_i && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nphy_toggle_input_capture.sv
// Toggle-mode DDR read capture: finds DQS edges in 8x oversampled data, picks the DQ byte
// CAPTURE_OFFSET samples later, packs bytes into 32-bit words and queues them in a FWFT FIFO.
module nphy_toggle_input_capture
    import nphy_toggle_pkg::*;
#(
    parameter int CAPTURE_OFFSET = 1
) (
    input  logic        iSystemClock,
    input  logic        iModuleReset,
    input  logic        iCaptureEnable,
    input  dqs_vec_t    iDQSSample,
    input  dq_vec_t     iDQSample,
    output logic [31:0] oPI_DQ,
    output logic        oPI_ValidFlag,
    input  logic        iPI_Ready,
    output logic        oPI_Empty,
    output logic        oPI_Full,
    output logic        oOverflow,
    output logic        oGlitch
);
    logic       hist_q;
    logic       last7_q;
    logic       glitch_q;
    dqs_vec_t   acc_c;
    logic       glitch_c;
    logic       prev_acc_c;
    logic       prev_s_c;

    dqs_vec_t   acc1_q;
    dq_vec_t    dq1_q;
    logic       en1_q;
    logic       en2_q;

    logic [6:0][7:0] hold_q, hold_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0][7:0] comb_c;
    logic [2:0]      fill_c;
    logic [3:0]      idx_c;
    logic            flush_c;
    word_t           word_q, word_d;
    logic            wvalid_q, wvalid_d;

    // An edge right after an accepted one is a glitch; ignored edges do not move the reference.
    always_comb begin
        acc_c      = '0;
        glitch_c   = 1'b0;
        prev_acc_c = last7_q;
        prev_s_c   = hist_q;
        for (int k = 0; k < SAMPLES_PER_CLK; k++) begin
            if (iCaptureEnable && (iDQSSample[k] != prev_s_c)) begin
                if (prev_acc_c) begin
                    glitch_c = 1'b1;
                end else begin
                    acc_c[k] = 1'b1;
                end
            end
            prev_acc_c = acc_c[k];
            prev_s_c   = iDQSSample[k];
        end
    end

    // Sample positions past bit 7 come from the live vector, which is the next cycle's data.
    always_comb begin
        comb_c = {8'h00, hold_q};
        fill_c = cnt_q;
        idx_c  = '0;
        for (int k = 0; k < SAMPLES_PER_CLK; k++) begin
            if (acc1_q[k]) begin
                idx_c          = 4'(k) + 4'(CAPTURE_OFFSET);
                comb_c[fill_c] = idx_c[3] ? iDQSample[idx_c[2:0]] : dq1_q[idx_c[2:0]];
                fill_c         = fill_c + 3'd1;
            end
        end
    end

    assign flush_c = en2_q && !en1_q;

    // Bytes above the fill level are always zero, so a flush word is already padded.
    always_comb begin
        hold_d   = comb_c[6:0];
        cnt_d    = fill_c;
        word_d   = comb_c[3:0];
        wvalid_d = 1'b0;
        if (fill_c >= 3'd4) begin
            wvalid_d = 1'b1;
            hold_d   = {32'h0, comb_c[6:4]};
            cnt_d    = fill_c - 3'd4;
        end else if (flush_c && (fill_c != 3'd0)) begin
            wvalid_d = 1'b1;
            hold_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (iModuleReset) begin
            hist_q   <= 1'b0;
            last7_q  <= 1'b0;
            glitch_q <= 1'b0;
            acc1_q   <= '0;
            dq1_q    <= '0;
            en1_q    <= 1'b0;
            en2_q    <= 1'b0;
            hold_q   <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
        end else begin
            hist_q   <= iDQSSample[SAMPLES_PER_CLK-1];
            last7_q  <= acc_c[SAMPLES_PER_CLK-1];
            glitch_q <= glitch_q | glitch_c;
            acc1_q   <= acc_c;
            dq1_q    <= iDQSample;
            en1_q    <= iCaptureEnable;
            en2_q    <= en1_q;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign oGlitch       = glitch_q;
    assign oPI_ValidFlag = !oPI_Empty;

    nphy_sync_fifo #(
        .WIDTH(32),
        .DEPTH(RD_FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (iSystemClock),
        .rst_i      (iModuleReset),
        .push_i     (wvalid_q),
        .data_i     (word_q),
        .pop_i      (oPI_ValidFlag && iPI_Ready),
        .data_o     (oPI_DQ),
        .empty_o    (oPI_Empty),
        .full_o     (oPI_Full),
        .overflow_o (oOverflow)
    );

endmodule

// File: tb/tb_nphy_toggle_input_capture.sv
// Bench for nphy_toggle_input_capture: directed bursts with literal words plus random bursts
// scored against a sample-stream model; a monitor pops expected words on every handshake.
module tb_nphy_toggle_input_capture;

    localparam int OFF = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  dqs;
    logic [63:0] dq;
    logic        ready;
    logic [31:0] dq_o;
    logic        valid;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        glitch;

    nphy_toggle_input_capture #(.CAPTURE_OFFSET(OFF)) dut (
        .iSystemClock   (clk),
        .iModuleReset   (rst),
        .iCaptureEnable (en),
        .iDQSSample     (dqs),
        .iDQSample      (dq),
        .oPI_DQ         (dq_o),
        .oPI_ValidFlag  (valid),
        .iPI_Ready      (ready),
        .oPI_Empty      (empty),
        .oPI_Full       (full),
        .oOverflow      (ovf),
        .oGlitch        (glitch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          words_seen = 0;
    logic        cur_lvl;
    bit          rand_ready;
    bit          glitch_exp;
    logic [7:0]  b_dqs[$];
    logic [63:0] b_dq[$];
    bit          b_en[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit e, input logic [7:0] s, input logic [63:0] d);
        @(posedge clk);
        #1;
        en = e;
        dqs = s;
        dq = d;
        cur_lvl = s[7];
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, {8{cur_lvl}}, {$urandom(), $urandom()});
    endtask

    task automatic clear_burst();
        b_dqs.delete();
        b_dq.delete();
        b_en.delete();
    endtask

    task automatic add_cycle(input bit e, input logic [7:0] s, input logic [63:0] d);
        b_en.push_back(e);
        b_dqs.push_back(s);
        b_dq.push_back(d);
    endtask

    task automatic drive_burst();
        foreach (b_en[i]) drive_cycle(b_en[i], b_dqs[i], b_dq[i]);
    endtask

    function automatic logic [63:0] put_byte(input logic [63:0] v, input int pos, input logic [7:0] b);
        logic [63:0] r;
        r = v;
        r[pos*8 +: 8] = b;
        return r;
    endfunction

    // DQS pattern 8'h33 toggles at samples 0,2,4,6; its bytes land at 1,3,5,7.
    function automatic logic [63:0] dq33(input int base);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        for (int i = 0; i < 4; i++) v = put_byte(v, 2 * i + 1, 8'(base + i));
        return v;
    endfunction

    function automatic logic [31:0] seq_word(input int c);
        return {8'(4 * c + 3), 8'(4 * c + 2), 8'(4 * c + 1), 8'(4 * c)};
    endfunction

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- reference model ----------------
    // Works on the flat sample stream: an edge is a level change between consecutive samples,
    // accepted only if enabled and at least 2 samples after the previous accepted edge.
    task automatic model_burst(input logic lvl0, output bit g);
        logic       s[$];
        logic [7:0] d[$];
        bit         e[$];
        logic [7:0] bytes[$];
        logic       prev;
        int         last;
        logic [31:0] w;
        g = 1'b0;
        foreach (b_en[i]) begin
            for (int j = 0; j < 8; j++) begin
                s.push_back(b_dqs[i][j]);
                d.push_back(b_dq[i][j*8 +: 8]);
                e.push_back(b_en[i]);
            end
        end
        last = -10;
        prev = lvl0;
        for (int t = 0; t < s.size(); t++) begin
            if (e[t] && (s[t] !== prev)) begin
                if (t - last < 2) g = 1'b1;
                else begin
                    last = t;
                    bytes.push_back(d[t + OFF]);
                end
            end
            prev = s[t];
        end
        while (bytes.size() >= 4) begin
            w = 32'h0;
            for (int i = 0; i < 4; i++) w[i*8 +: 8] = bytes.pop_front();
            exp_q.push_back(w);
        end
        if (bytes.size() > 0) begin
            w = 32'h0;
            for (int i = 0; bytes.size() > 0; i++) w[i*8 +: 8] = bytes.pop_front();
            exp_q.push_back(w);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && valid && ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h while no word was expected", dq_o);
                end else begin
                    check("word", dq_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int start;
        int ws;
        bit g;
        int len;
        int tail;
        logic lvl;
        logic [7:0] s;

        rst = 1'b1; en = 1'b0; dqs = 8'h00; dq = 64'h0; ready = 1'b0;
        rand_ready = 1'b0; cur_lvl = 1'b0; glitch_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(ovf), 32'd0);
        check("rst_glitch", 32'(glitch), 32'd0);
        check("rst_dq", dq_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Four enabled cycles, toggle every 2 samples, bytes 0x00..0x0F.
        ready = 1'b1;
        clear_burst();
        for (int c = 0; c < 4; c++) add_cycle(1'b1, 8'h33, dq33(4 * c));
        add_cycle(1'b0, 8'h00, {$urandom(), $urandom()});
        for (int c = 0; c < 4; c++) exp_q.push_back(seq_word(c));
        fork
            drive_burst();
            begin
                @(posedge clk);
                #2;
                start = cyc;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (valid) break;
                end
                check("first_valid_latency", 32'(cyc - start), 32'd3);
            end
        join
        wait_drain("drain_basic");

        // Edge at sample 7 picks its byte from sample 0 of the next cycle.
        clear_burst();
        add_cycle(1'b1, 8'h80, {$urandom(), $urandom()});
        add_cycle(1'b1, 8'h19, put_byte(put_byte(put_byte(put_byte({$urandom(), $urandom()},
                  0, 8'hA0), 2, 8'hA1), 4, 8'hA2), 6, 8'hA3));
        add_cycle(1'b0, 8'h00, {$urandom(), $urandom()});
        exp_q.push_back(32'hA3A2A1A0);
        drive_burst();
        wait_drain("drain_wrap");

        // Six bytes then enable falls: full word plus a zero-padded flush word, nothing else.
        ws = words_seen;
        clear_burst();
        add_cycle(1'b1, 8'h33, dq33(0));
        add_cycle(1'b1, 8'h03, put_byte(put_byte({$urandom(), $urandom()}, 1, 8'h04), 3, 8'h05));
        add_cycle(1'b0, 8'h00, {$urandom(), $urandom()});
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h00000504);
        drive_burst();
        wait_drain("drain_flush");
        idle(6);
        check("flush_word_count", 32'(words_seen - ws), 32'd2);
        check("glitch_before", 32'(glitch), 32'd0);

        // Edges at samples 3 and 4: second is a glitch, one byte survives.
        ws = words_seen;
        clear_burst();
        add_cycle(1'b1, 8'h08, put_byte({$urandom(), $urandom()}, 4, 8'h5A));
        add_cycle(1'b0, 8'h00, {$urandom(), $urandom()});
        exp_q.push_back(32'h0000005A);
        drive_burst();
        wait_drain("drain_glitch");
        idle(4);
        check("glitch_word_count", 32'(words_seen - ws), 32'd1);
        check("glitch_after", 32'(glitch), 32'd1);

        // Three words queued and two bytes held, then reset: everything discarded.
        ready = 1'b0;
        clear_burst();
        for (int c = 0; c < 3; c++) add_cycle(1'b1, 8'h33, dq33(4 * c));
        add_cycle(1'b1, 8'h03, dq33(12));
        for (int c = 0; c < 3; c++) add_cycle(1'b1, 8'h00, {$urandom(), $urandom()});
        drive_burst();
        @(negedge clk);
        check("queued_before_reset", 32'(empty), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_glitch", 32'(glitch), 32'd0);
        check("reset_dq", dq_o, 32'h0);
        ws = words_seen;
        ready = 1'b1;
        idle(10);
        check("no_word_after_reset", 32'(words_seen - ws), 32'd0);

        // Random bursts against the model, with random backpressure.
        rand_ready = 1'b1;
        for (int b = 0; b < 40; b++) begin
            clear_burst();
            len = $urandom_range(1, 5);
            tail = $urandom_range(2, 4);
            lvl = cur_lvl;
            for (int c = 0; c < len + tail; c++) begin
                for (int j = 0; j < 8; j++) begin
                    if ($urandom_range(0, 2) == 0) lvl = ~lvl;
                    s[j] = lvl;
                end
                add_cycle(c < len, s, {$urandom(), $urandom()});
            end
            model_burst(cur_lvl, g);
            glitch_exp = glitch_exp | g;
            drive_burst();
            idle(1);
            wait_drain("drain_random");
        end
        rand_ready = 1'b0;
        #2;
        ready = 1'b1;
        idle(6);
        check("random_glitch", 32'(glitch), 32'(glitch_exp));
        check("random_no_overflow", 32'(ovf), 32'd0);

        // Twelve words with ready low: eight kept, overflow flagged, kept words drain intact.
        ready = 1'b0;
        ws = words_seen;
        clear_burst();
        for (int c = 0; c < 12; c++) add_cycle(1'b1, 8'h33, dq33(4 * c));
        add_cycle(1'b0, 8'h00, {$urandom(), $urandom()});
        drive_burst();
        idle(5);
        @(negedge clk);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_valid", 32'(valid), 32'd1);
        check("ovf_head", dq_o, seq_word(0));
        for (int c = 0; c < 8; c++) exp_q.push_back(seq_word(c));
        @(posedge clk);
        #1 ready = 1'b1;
        wait_drain("drain_overflow");
        idle(6);
        @(negedge clk);
        check("ovf_drain_count", 32'(words_seen - ws), 32'd8);
        check("ovf_empty_after", 32'(empty), 32'd1);
        check("ovf_not_full_after", 32'(full), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
